// File: rtl/interrupt_sequencer_if.sv
// Purpose : bundles the request/decode inputs and redirect/status outputs of the interrupt sequencer.
// Latency : none, wiring only.
// Backpres: none; decode pulses and redirect strobes are single-cycle, with no handshake.
interface interrupt_sequencer_if;
  logic        intr;
  logic [31:0] pc_cur;
  logic        sti;
  logic        cli;
  logic        reti;
  logic        ISR;
  logic [2:0]  LISR;
  logic [31:0] PC_in;
  logic        pc_ld;
  logic        Flush;
  logic        int_ack;
  logic [31:0] epc;
  logic        in_isr;

  // Pipeline side: drives the request and decode pulses, consumes the redirect.
  modport master (
    output intr, pc_cur, sti, cli, reti,
    input  ISR, LISR, PC_in, pc_ld, Flush, int_ack, epc, in_isr
  );

  // Sequencer side.
  modport slave (
    input  intr, pc_cur, sti, cli, reti,
    output ISR, LISR, PC_in, pc_ld, Flush, int_ack, epc, in_isr
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// Purpose : Moore sequencer for a single non-nesting interrupt: saves the PC, redirects to ISR_VECTOR, then returns through three exit phases.
// Latency : ISR rises 1 cycle after the request is sampled (3 with INT_SYNC_EN), pc_ld follows 1 cycle later, and exit takes 3 cycles.
// Backpres: none; intr is a level and stays pending while masked or in service.
// Option  : define INT_SYNC_EN to pass intr through a 2-flop synchronizer.
module interrupt_sequencer #(
  parameter logic [31:0] ISR_VECTOR = 32'h0000_0800
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENT_SAVE = 3'd1,
    S_ENT_LOAD = 3'd2,
    S_IN_ISR   = 3'd3,
    S_EXIT1    = 3'd4,
    S_EXIT2    = 3'd5,
    S_EXIT3    = 3'd6
  } state_t;

  state_t      r_state;
  logic        r_ie;
  logic [31:0] r_epc;
  logic        r_isr;
  logic [2:0]  r_lisr;
  logic [31:0] r_pc_in;
  logic        r_pc_ld;
  logic        r_flush;
  logic        r_int_ack;
  logic        r_in_isr;
  logic        w_req;

`ifdef INT_SYNC_EN
  logic [1:0] r_sync;

  // Two-flop synchronizer for the asynchronous interrupt level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], bus.intr};
    end
  end

  assign w_req = r_sync[1];
`else
  assign w_req = bus.intr;
`endif

  // State, enable flag, saved PC and outputs. Outputs are loaded with the values
  // belonging to the state being entered, so each one is a pure function of the
  // current state and of the saved PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ie      <= 1'b0;
      r_epc     <= 32'h0;
      r_isr     <= 1'b0;
      r_lisr    <= 3'b000;
      r_pc_in   <= 32'h0;
      r_pc_ld   <= 1'b0;
      r_flush   <= 1'b0;
      r_int_ack <= 1'b0;
      r_in_isr  <= 1'b0;
    end else begin
      r_isr     <= 1'b0;
      r_lisr    <= 3'b000;
      r_pc_in   <= 32'h0;
      r_pc_ld   <= 1'b0;
      r_flush   <= 1'b0;
      r_int_ack <= 1'b0;
      r_in_isr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The enable flag is only writable here; cli beats sti and also
          // vetoes an entry in the same cycle.
          if (bus.cli) begin
            r_ie <= 1'b0;
          end else if (bus.sti) begin
            r_ie <= 1'b1;
          end
          if (w_req && r_ie && !bus.cli) begin
            r_state <= S_ENT_SAVE;
            r_epc   <= bus.pc_cur;
            r_isr   <= 1'b1;
            r_flush <= 1'b1;
          end
        end
        S_ENT_SAVE: begin
          r_state   <= S_ENT_LOAD;
          r_isr     <= 1'b1;
          r_flush   <= 1'b1;
          r_pc_ld   <= 1'b1;
          r_pc_in   <= ISR_VECTOR;
          r_int_ack <= 1'b1;
        end
        S_ENT_LOAD: begin
          r_state  <= S_IN_ISR;
          r_ie     <= 1'b0;
          r_in_isr <= 1'b1;
        end
        S_IN_ISR: begin
          // intr is deliberately not looked at here: no nesting.
          if (bus.reti) begin
            r_state <= S_EXIT1;
            r_lisr  <= 3'b001;
            r_flush <= 1'b1;
          end else begin
            r_in_isr <= 1'b1;
          end
        end
        S_EXIT1: begin
          r_state <= S_EXIT2;
          r_lisr  <= 3'b010;
          r_flush <= 1'b1;
        end
        S_EXIT2: begin
          r_state <= S_EXIT3;
          r_lisr  <= 3'b100;
          r_pc_ld <= 1'b1;
          r_pc_in <= r_epc;
        end
        S_EXIT3: begin
          // Always pass through IDLE; a still-pending intr re-enters one cycle later.
          r_state <= S_IDLE;
          r_ie    <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ISR     = r_isr;
  assign bus.LISR    = r_lisr;
  assign bus.PC_in   = r_pc_in;
  assign bus.pc_ld   = r_pc_ld;
  assign bus.Flush   = r_flush;
  assign bus.int_ack = r_int_ack;
  assign bus.epc     = r_epc;
  assign bus.in_isr  = r_in_isr;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios followed by randomized traffic against a phase-count reference model.
module tb_interrupt_sequencer;
  localparam logic [31:0] VEC = 32'h0000_0800;
`ifdef INT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  interrupt_sequencer_if bus();

  interrupt_sequencer #(.ISR_VECTOR(VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [71:0] dut_vec;
  assign dut_vec = {bus.ISR, bus.LISR, bus.PC_in, bus.pc_ld, bus.Flush,
                    bus.int_ack, bus.epc, bus.in_isr};

  // Reference model: the service is a walk through phases 0..6
  // (0 idle, 1-2 entry, 3 in service, 4-6 exit).
  int          m_phase;
  logic        m_ie;
  logic [31:0] m_epc;
  logic [1:0]  m_hist;

  task automatic model_reset();
    m_phase = 0;
    m_ie    = 1'b0;
    m_epc   = 32'h0;
    m_hist  = 2'b00;
  endtask

  // Advance the model by one clock using the inputs as they stand before the edge.
  task automatic model_step();
    logic [2:0] w;
    logic       req;
    w      = {m_hist, bus.intr};
    req    = w[SYNC];
    m_hist = w[1:0];
    if (m_phase == 0) begin
      if (req && m_ie && !bus.cli) begin
        m_epc   = bus.pc_cur;
        m_phase = 1;
      end
      if (bus.cli) m_ie = 1'b0;
      else if (bus.sti) m_ie = 1'b1;
    end else if (m_phase == 2) begin
      m_ie    = 1'b0;
      m_phase = 3;
    end else if (m_phase == 3) begin
      if (bus.reti) m_phase = 4;
    end else if (m_phase == 6) begin
      m_ie    = 1'b1;
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  endtask

  function automatic logic [71:0] model_vec();
    logic        isr, pl, fl, ack, ii;
    logic [2:0]  l;
    logic [31:0] pci;
    isr = (m_phase == 1) || (m_phase == 2);
    l   = (m_phase >= 4) ? 3'(1 << (m_phase - 4)) : 3'b000;
    pci = (m_phase == 2) ? VEC : ((m_phase == 6) ? m_epc : 32'h0);
    pl  = (m_phase == 2) || (m_phase == 6);
    fl  = (m_phase == 1) || (m_phase == 2) || (m_phase == 4) || (m_phase == 5);
    ack = (m_phase == 2);
    ii  = (m_phase == 3);
    return {isr, l, pci, pl, fl, ack, m_epc, ii};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic [31:0] pc, input logic s,
                       input logic c, input logic r);
    bus.intr   = i;
    bus.pc_cur = pc;
    bus.sti    = s;
    bus.cli    = c;
    bus.reti   = r;
  endtask

  // Finish whatever entry/service is in progress and return to IDLE with ie=1.
  task automatic leave_service();
    bus.intr = 1'b0;
    repeat (3) tick();
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    logic bad;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    n_total++;
    if (dut_vec !== 72'h0) $display("FAIL reset_outputs: got %h want 0", dut_vec);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if (dut_vec !== 72'h0) $display("FAIL reset_held: got %h want 0", dut_vec);
    else n_pass++;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (bus.ISR !== 1'b0 || bus.pc_ld !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL reset_ie_clear: entry seen=%b want 0", bad);
    else n_pass++;
    bus.intr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_entry();
    logic bad;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    bad = 1'b0;
    repeat (SYNC) begin
      tick();
      if (bus.ISR !== 1'b0) bad = 1'b1;
    end
    tick();
    n_total++;
    if ({bad, bus.ISR, bus.Flush, bus.pc_ld, bus.int_ack} !== 5'b01100)
      $display("FAIL entry_save: got early=%b ISR=%b Flush=%b pc_ld=%b ack=%b want 0 1 1 0 0",
               bad, bus.ISR, bus.Flush, bus.pc_ld, bus.int_ack);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ISR, bus.Flush, bus.pc_ld, bus.int_ack} !== 4'b1111 || bus.PC_in !== VEC)
      $display("FAIL entry_load: got ISR/Flush/pc_ld/ack=%b PC_in=%h want 1111 %h",
               {bus.ISR, bus.Flush, bus.pc_ld, bus.int_ack}, bus.PC_in, VEC);
    else n_pass++;
    n_total++;
    if (bus.epc !== 32'h0000_0040) $display("FAIL entry_epc: got %h want 00000040", bus.epc);
    else n_pass++;
    drive(1'b0, 32'h0000_0044, 1'b0, 1'b0, 1'b0);
    tick();
    n_total++;
    if ({bus.in_isr, bus.ISR, bus.pc_ld, bus.int_ack} !== 4'b1000)
      $display("FAIL entry_in_isr: got %b want 1000", {bus.in_isr, bus.ISR, bus.pc_ld, bus.int_ack});
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (bus.in_isr !== 1'b1 || bus.epc !== 32'h0000_0040)
      $display("FAIL entry_hold: got in_isr=%b epc=%h want 1 00000040", bus.in_isr, bus.epc);
    else n_pass++;
  endtask

  task automatic test_exit();
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    n_total++;
    if ({bus.LISR, bus.Flush, bus.pc_ld, bus.in_isr} !== 6'b001100)
      $display("FAIL exit1: got %b want 001100", {bus.LISR, bus.Flush, bus.pc_ld, bus.in_isr});
    else n_pass++;
    tick();
    n_total++;
    if ({bus.LISR, bus.Flush, bus.pc_ld} !== 5'b01010)
      $display("FAIL exit2: got %b want 01010", {bus.LISR, bus.Flush, bus.pc_ld});
    else n_pass++;
    tick();
    n_total++;
    if ({bus.LISR, bus.Flush, bus.pc_ld} !== 5'b10001 || bus.PC_in !== 32'h0000_0040)
      $display("FAIL exit3: got %b PC_in=%h want 10001 00000040",
               {bus.LISR, bus.Flush, bus.pc_ld}, bus.PC_in);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ISR, bus.LISR, bus.pc_ld, bus.Flush, bus.int_ack, bus.in_isr} !== 8'h00 ||
        bus.PC_in !== 32'h0)
      $display("FAIL exit_idle: got %b PC_in=%h want 0 0",
               {bus.ISR, bus.LISR, bus.pc_ld, bus.Flush, bus.int_ack, bus.in_isr}, bus.PC_in);
    else n_pass++;
    drive(1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    repeat (SYNC + 1) tick();
    n_total++;
    if (bus.ISR !== 1'b1) $display("FAIL exit_ie_restored: got ISR=%b want 1", bus.ISR);
    else n_pass++;
    leave_service();
  endtask

  task automatic test_masking();
    logic bad;
    drive(1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (bus.ISR !== 1'b0 || bus.pc_ld !== 1'b0 || bus.int_ack !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL mask_ie0: entry seen=%b want 0", bad);
    else n_pass++;
    drive(1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    tick();
    bus.reti = 1'b0;
    n_total++;
    if (bus.LISR !== 3'b000 || bus.pc_ld !== 1'b0)
      $display("FAIL reti_idle: got LISR=%b pc_ld=%b want 000 0", bus.LISR, bus.pc_ld);
    else n_pass++;
    bus.sti = 1'b1;
    tick();
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0);
    bad = 1'b0;
    tick();
    if (bus.ISR !== 1'b0) bad = 1'b1;
    bus.cli = 1'b0;
    repeat (5) begin
      tick();
      if (bus.ISR !== 1'b0 || bus.int_ack !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL mask_cli_wins: entry seen=%b want 0", bad);
    else n_pass++;
    bus.intr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_no_nesting();
    logic bad;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    repeat (SYNC + 1) tick();
    tick();
    n_total++;
    if (bus.epc !== 32'h0000_0100 || bus.int_ack !== 1'b1)
      $display("FAIL nest_entry: got epc=%h ack=%b want 00000100 1", bus.epc, bus.int_ack);
    else n_pass++;
    bad = 1'b0;
    repeat (6) begin
      tick();
      if (bus.in_isr !== 1'b1 || bus.ISR !== 1'b0 || bus.int_ack !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL no_nesting: reentry seen=%b want 0", bad);
    else n_pass++;
    drive(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1);
    tick();
    bus.reti = 1'b0;
    repeat (2) tick();
    n_total++;
    if (bus.LISR !== 3'b100 || bus.PC_in !== 32'h0000_0100)
      $display("FAIL nest_exit3: got LISR=%b PC_in=%h want 100 00000100", bus.LISR, bus.PC_in);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ISR, bus.LISR, bus.in_isr} !== 5'b00000)
      $display("FAIL reentry_idle: got %b want 00000", {bus.ISR, bus.LISR, bus.in_isr});
    else n_pass++;
    tick();
    n_total++;
    if ({bus.ISR, bus.Flush} !== 2'b11)
      $display("FAIL reentry_save: got ISR/Flush=%b want 11", {bus.ISR, bus.Flush});
    else n_pass++;
    tick();
    n_total++;
    if (bus.epc !== 32'h0000_0200 || bus.int_ack !== 1'b1)
      $display("FAIL reentry_epc: got epc=%h ack=%b want 00000200 1", bus.epc, bus.int_ack);
    else n_pass++;
    leave_service();
  endtask

  task automatic test_reset_mid();
    logic bad;
    drive(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
    repeat (SYNC + 1) tick();
    bus.intr = 1'b0;
    repeat (2) tick();
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    tick();
    n_total++;
    if (bus.LISR !== 3'b010) $display("FAIL mid_reach_exit2: got LISR=%b want 010", bus.LISR);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_total++;
    if (dut_vec !== 72'h0) $display("FAIL reset_mid_outputs: got %h want 0", dut_vec);
    else n_pass++;
    bus.intr = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (bus.ISR !== 1'b0 || bus.pc_ld !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL reset_mid_masked: entry seen=%b want 0", bad);
    else n_pass++;
    bus.sti = 1'b1;
    tick();
    bus.sti = 1'b0;
    tick();
    n_total++;
    if (bus.ISR !== 1'b1 || bus.epc !== 32'h0000_0300)
      $display("FAIL reset_mid_sti: got ISR=%b epc=%h want 1 00000300", bus.ISR, bus.epc);
    else n_pass++;
    leave_service();
  endtask

  task automatic test_sync_latency();
    bus.intr = 1'b0;
    repeat (3) tick();
    bus.intr = 1'b1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      n_total++;
      if (bus.ISR !== (k == SYNC + 1))
        $display("FAIL sync_latency: cycle %0d got ISR=%b want %b", k, bus.ISR, (k == SYNC + 1));
      else n_pass++;
    end
    leave_service();
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom % 3) == 0, $urandom & 32'hFFFF_FFFC, ($urandom % 4) == 0,
            ($urandom % 8) == 0, ($urandom % 4) == 0);
      if (($urandom % 300) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        n_total++;
        if (dut_vec !== 72'h0) $display("FAIL random_reset: got %h want 0", dut_vec);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      tick();
      n_total++;
      if (dut_vec !== model_vec())
        $display("FAIL random_cycle %0d: got %h want %h", n, dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    test_reset();
    test_entry();
    test_exit();
    test_masking();
    test_no_nesting();
    test_reset_mid();
    test_sync_latency();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "time limit");
  end
endmodule
